// File: rtl/brick_game_engine.sv
// Paddle/ball/brick game engine: ball physics, brick bitmap, score/lives and the
// serve/win/lose sequence, stepped by a one-cycle frame tick on the system clock.

module brick_cell #(
  parameter int XL    = 0,
  parameter int XH    = 0,
  parameter int YL    = 0,
  parameter int YH    = 0,
  parameter bit COLOR = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scan_en,
  input  logic       sel,
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  input  logic [9:0] h_cnt,
  input  logic [9:0] v_cnt,
  output logic       take,
  output logic       pix_on,
  output logic       pix_col
);
  localparam logic [10:0] XL_C = 11'(XL);
  localparam logic [10:0] XH_C = 11'(XH);
  localparam logic [10:0] YL_C = 11'(YL);
  localparam logic [10:0] YH_C = 11'(YH);

  logic hit, ball_in, pix_in;

  assign ball_in = ({1'b0, ball_x} >= XL_C) && ({1'b0, ball_x} <= XH_C) &&
                   ({1'b0, ball_y} >= YL_C) && ({1'b0, ball_y} <= YH_C);
  assign pix_in  = ({1'b0, h_cnt} >= XL_C) && ({1'b0, h_cnt} <= XH_C) &&
                   ({1'b0, v_cnt} >= YL_C) && ({1'b0, v_cnt} <= YH_C);
  assign take    = scan_en & sel & ball_in & ~hit;
  assign pix_on  = pix_in & ~hit;
  assign pix_col = pix_in & COLOR;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      hit <= 1'b0;
    else if (take) hit <= 1'b1;
  end
endmodule

module brick_game_engine #(
  parameter int ROWS          = 5,
  parameter int COLS          = 12,
  parameter int BRICK_W       = 53,
  parameter int BRICK_H       = 25,
  parameter int LEFT_WALL_X   = 144,
  parameter int RIGHT_WALL_X  = 783,
  parameter int CEILING_Y     = 35,
  parameter int FLOOR_Y       = 515,
  parameter int BALL_HALF     = 4,
  parameter int PADDLE_Y      = 500,
  parameter int PADDLE_HALF_W = 25,
  parameter int SPEED         = 2,
  parameter int LIVES         = 3,
  localparam int NB           = ROWS * COLS,
  localparam int BLW          = $clog2(NB + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tick,
  input  logic           launch,
  input  logic [9:0]     paddle_x,
  input  logic [9:0]     hCount,
  input  logic [9:0]     vCount,
  output logic [9:0]     ball_x,
  output logic [9:0]     ball_y,
  output logic           brick_fill,
  output logic           brick_color,
  output logic [BLW-1:0] bricks_left,
  output logic [15:0]    score,
  output logic [2:0]     lives,
  output logic           busy,
  output logic           game_over,
  output logic           win
);
  localparam logic [9:0] L_TRIG  = 10'(LEFT_WALL_X + BALL_HALF);
  localparam logic [9:0] L_SET   = 10'(LEFT_WALL_X + BALL_HALF + 1);
  localparam logic [9:0] R_TRIG  = 10'(RIGHT_WALL_X - BALL_HALF);
  localparam logic [9:0] R_SET   = 10'(RIGHT_WALL_X - BALL_HALF - 1);
  localparam logic [9:0] C_TRIG  = 10'(CEILING_Y + BALL_HALF);
  localparam logic [9:0] C_SET   = 10'(CEILING_Y + BALL_HALF + 1);
  localparam logic [9:0] P_TOP   = 10'(PADDLE_Y - 5 - BALL_HALF);
  localparam logic [9:0] P_BOT   = 10'(PADDLE_Y);
  localparam logic [9:0] P_REACH = 10'(PADDLE_HALF_W + BALL_HALF);
  localparam logic [9:0] F_TRIG  = 10'(FLOOR_Y - BALL_HALF);
  localparam logic [9:0] SERVE_Y = 10'(PADDLE_Y - 6 - BALL_HALF);
  localparam logic [9:0] HOME_X  = 10'((LEFT_WALL_X + RIGHT_WALL_X) / 2);
  localparam logic [9:0] STEP    = 10'(SPEED);
  localparam logic [BLW-1:0] NB_C   = BLW'(NB);
  localparam logic [BLW-1:0] LAST_K = BLW'(NB - 1);

  typedef enum logic [2:0] {SERVE, IDLE, MOVE, BOUNCE, SCAN, WIN, LOSE} state_t;

  state_t         state;
  logic           vx_neg, vy_neg;
  logic [BLW-1:0] k;
  logic [NB-1:0]  take, pix_on, pix_col;
  logic           found, in_scan;

  assign in_scan = (state == SCAN);
  assign found   = |take;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam int B = r * COLS + c;
      brick_cell #(
        .XL(LEFT_WALL_X + c * BRICK_W), .XH(LEFT_WALL_X + (c + 1) * BRICK_W - 1),
        .YL(CEILING_Y + r * BRICK_H),   .YH(CEILING_Y + (r + 1) * BRICK_H - 1),
        .COLOR(1'((r + c) % 2))
      ) u_cell (
        .clk(clk), .rst(rst), .scan_en(in_scan), .sel(k == BLW'(B)),
        .ball_x(ball_x), .ball_y(ball_y), .h_cnt(hCount), .v_cnt(vCount),
        .take(take[B]), .pix_on(pix_on[B]), .pix_col(pix_col[B])
      );
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      brick_fill  <= 1'b0;
      brick_color <= 1'b0;
    end else begin
      brick_fill  <= |pix_on;
      brick_color <= |pix_col;
    end
  end

  // Bounce resolution: each check sees the result of the earlier ones.
  logic [9:0] nx, ny, dx;
  logic       nvx, nvy, floor_hit;

  always_comb begin
    nx        = ball_x;
    ny        = ball_y;
    nvx       = vx_neg;
    nvy       = vy_neg;
    floor_hit = 1'b0;
    if (nx <= L_TRIG) begin nx = L_SET; nvx = 1'b0; end
    if (nx >= R_TRIG) begin nx = R_SET; nvx = 1'b1; end
    if (ny <= C_TRIG) begin ny = C_SET; nvy = 1'b0; end
    dx = (nx >= paddle_x) ? nx - paddle_x : paddle_x - nx;
    if (!nvy && ny >= P_TOP && ny <= P_BOT && dx <= P_REACH) begin
      nvx = (nx < paddle_x);
      ny  = SERVE_Y;
      nvy = 1'b1;
    end else if (ny >= F_TRIG) begin
      floor_hit = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= SERVE;
      ball_x      <= HOME_X;
      ball_y      <= SERVE_Y;
      vx_neg      <= 1'b0;
      vy_neg      <= 1'b1;
      k           <= '0;
      bricks_left <= NB_C;
      score       <= 16'd0;
      lives       <= 3'(LIVES);
    end else begin
      case (state)
        SERVE: begin
          if (tick) begin
            ball_x <= paddle_x;
            ball_y <= SERVE_Y;
          end
          if (launch) begin
            vx_neg <= 1'b0;
            vy_neg <= 1'b1;
            state  <= IDLE;
          end
        end
        IDLE: if (tick) state <= MOVE;
        MOVE: begin
          ball_x <= vx_neg ? ball_x - STEP : ball_x + STEP;
          ball_y <= vy_neg ? ball_y - STEP : ball_y + STEP;
          state  <= BOUNCE;
        end
        BOUNCE: begin
          ball_x <= nx;
          ball_y <= ny;
          vx_neg <= nvx;
          vy_neg <= nvy;
          if (floor_hit) begin
            lives <= lives - 3'd1;
            state <= (lives == 3'd1) ? LOSE : SERVE;
          end else begin
            k     <= '0;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (found) begin
            bricks_left <= bricks_left - BLW'(1);
            if (score != 16'hFFFF) score <= score + 16'd1;
            vy_neg <= ~vy_neg;
            state  <= (bricks_left == BLW'(1)) ? WIN : IDLE;
          end else if (k == LAST_K) begin
            state <= IDLE;
          end else begin
            k <= k + BLW'(1);
          end
        end
        default: state <= state;
      endcase
    end
  end

  assign busy      = (state == MOVE) || (state == BOUNCE) || (state == SCAN);
  assign game_over = (state == LOSE);
  assign win       = (state == WIN);
endmodule
